hazard_control_unit: RTL and testbench

//  Parametrised pipeline hazard controller for the 5-stage MIPS core.
//  - Load-use stalls lasting LOAD_LATENCY cycles (multi-cycle data RAM).
//  - Whole-pipe freeze while data memory is not ready.
//  - Control-hazard flushes for jumps (resolved in ID) and taken branches (resolved in EX).

---
 rtl/hazard_control_unit_if.sv | 36 +++
 rtl/hazard_control_unit.sv | 148 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_control_unit_if.sv
// Hazard-unit bundle: pipeline status in, stage enables/flushes out.
// master = pipeline datapath side, slave = hazard_control_unit.
interface hazard_control_unit_if #(
    parameter int REG_W = 5
);
    logic             mem_read_ex;
    logic [REG_W-1:0] rt_ex;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             uses_rt_id;
    logic             jump_id;
    logic             branch_taken_ex;
    logic             mem_access_mem;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             pipe_freeze;

    modport master (
        output mem_read_ex, rt_ex, rs_id, rt_id, uses_rt_id,
               jump_id, branch_taken_ex, mem_access_mem, dmem_ready,
        input  pc_write, if_id_write, id_ex_bubble,
               if_id_flush, id_ex_flush, pipe_freeze
    );

    modport slave (
        input  mem_read_ex, rt_ex, rs_id, rt_id, uses_rt_id,
               jump_id, branch_taken_ex, mem_access_mem, dmem_ready,
        output pc_write, if_id_write, id_ex_bubble,
               if_id_flush, id_ex_flush, pipe_freeze
    );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use stall / memory freeze / control flush controller for the 5-stage MIPS pipe.
// Optional perf counters (stall_cnt, flush_cnt) exist only when HAZARD_PERF_CNT_EN is defined.
module hazard_control_unit #(
    parameter int REG_W        = 5,
    parameter int LOAD_LATENCY = 1,
    parameter int CNT_W        = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_control_unit_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_e;

    localparam logic [2:0] LCNT_INIT = 3'(LOAD_LATENCY - 1);

    state_e     state_q, state_d;
    state_e     saved_q, saved_d;
    state_e     eff_state;
    logic [2:0] lcnt_q, lcnt_d;

    logic [REG_W-1:0] rt_ex, rs_id, rt_id;
    logic             hazard;
    logic             freeze;

    logic pc_write_c, if_id_write_c, bubble_c, if_id_flush_c, id_ex_flush_c, freeze_c;

    assign rt_ex = hz.rt_ex;
    assign rs_id = hz.rs_id;
    assign rt_id = hz.rt_id;

    assign hazard = hz.mem_read_ex && (rt_ex != {REG_W{1'b0}}) &&
                    ((rt_ex == rs_id) || (hz.uses_rt_id && (rt_ex == rt_id)));
    assign freeze = hz.mem_access_mem && !hz.dmem_ready;

    // While waiting on memory the pre-freeze state lives in saved_q and resumes transparently.
    assign eff_state = (state_q == MEM_WAIT) ? saved_q : state_q;

    // NOTE: every signal gets a default before any branch so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        saved_d       = saved_q;
        lcnt_d        = lcnt_q;
        pc_write_c    = 1'b1;
        if_id_write_c = 1'b1;
        bubble_c      = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_flush_c = 1'b0;
        freeze_c      = 1'b0;

        if (freeze) begin
            freeze_c      = 1'b1;
            pc_write_c    = 1'b0;
            if_id_write_c = 1'b0;
            if (state_q != MEM_WAIT) begin
                saved_d = state_q;
            end
            state_d = MEM_WAIT;
        end else begin
            state_d = eff_state;
            if (hz.branch_taken_ex) begin
                if_id_flush_c = 1'b1;
                id_ex_flush_c = 1'b1;
                state_d       = RUN;
                lcnt_d        = 3'd0;
            end else if (eff_state == LOAD_STALL) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                bubble_c      = 1'b1;
                lcnt_d        = lcnt_q - 3'd1;
                if (lcnt_q <= 3'd1) begin
                    state_d = RUN;
                    lcnt_d  = 3'd0;
                end
            end else if (hazard) begin
                pc_write_c    = 1'b0;
                if_id_write_c = 1'b0;
                bubble_c      = 1'b1;
                if (LOAD_LATENCY > 1) begin
                    lcnt_d  = LCNT_INIT;
                    state_d = LOAD_STALL;
                end
            end else if (hz.jump_id) begin
                if_id_flush_c = 1'b1;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            saved_q <= RUN;
            lcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            lcnt_q  <= lcnt_d;
        end
    end

    // Reset holds the whole pipe, PC included.
    assign hz.pc_write     = reset && pc_write_c;
    assign hz.if_id_write  = reset && if_id_write_c;
    assign hz.id_ex_bubble = reset && bubble_c;
    assign hz.if_id_flush  = reset && if_id_flush_c;
    assign hz.id_ex_flush  = reset && id_ex_flush_c;
    assign hz.pipe_freeze  = reset && freeze_c;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if ((bubble_c || freeze_c) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (if_id_flush_c && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench: two units (LOAD_LATENCY 1 and 3) driven per cycle, outputs checked mid-cycle.
// Perf-counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_hazard_control_unit;

    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_control_unit_if #(.REG_W(5)) hz1 ();
    hazard_control_unit_if #(.REG_W(5)) hz3 ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;
`endif

    hazard_control_unit #(.REG_W(5), .LOAD_LATENCY(1), .CNT_W(32)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz1.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt1),
        .flush_cnt (flush_cnt1)
`endif
    );

    hazard_control_unit #(.REG_W(5), .LOAD_LATENCY(3), .CNT_W(32)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .hz    (hz3.slave)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt (stall_cnt3),
        .flush_cnt (flush_cnt3)
`endif
    );

    typedef struct packed {
        logic       mr;
        logic [4:0] rt_ex;
        logic [4:0] rs_id;
        logic [4:0] rt_id;
        logic       urt;
        logic       jump;
        logic       br;
        logic       ma;
        logic       rdy;
    } in_t;

    typedef struct {
        string      tag;
        int         dut;
        logic [5:0] exp;
        logic [5:0] mask;
    } exp_t;

    // Output vector order: {pc_write, if_id_write, id_ex_bubble, if_id_flush, id_ex_flush, pipe_freeze}
    localparam logic [5:0] O_RUN   = 6'b110000;
    localparam logic [5:0] O_STALL = 6'b001000;
    localparam logic [5:0] O_BR    = 6'b100110;
    localparam logic [5:0] O_JMP   = 6'b100100;
    localparam logic [5:0] O_FRZ   = 6'b000001;
    localparam logic [5:0] O_RST   = 6'b000000;
    localparam logic [5:0] M_ALL   = 6'b111111;
    localparam logic [5:0] M_FLUSH = 6'b101111;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    logic [5:0] out1, out3;
    assign out1 = {hz1.pc_write, hz1.if_id_write, hz1.id_ex_bubble,
                   hz1.if_id_flush, hz1.id_ex_flush, hz1.pipe_freeze};
    assign out3 = {hz3.pc_write, hz3.if_id_write, hz3.id_ex_bubble,
                   hz3.if_id_flush, hz3.id_ex_flush, hz3.pipe_freeze};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic in_t mk_in(logic mr, logic [4:0] rtex, logic [4:0] rsid, logic [4:0] rtid,
                                  logic urt, logic j, logic br, logic ma, logic rdy);
        in_t v;
        v = '{mr: mr, rt_ex: rtex, rs_id: rsid, rt_id: rtid, urt: urt,
              jump: j, br: br, ma: ma, rdy: rdy};
        return v;
    endfunction

    in_t idle;

    task automatic drive1(input in_t v);
        hz1.mem_read_ex     = v.mr;
        hz1.rt_ex           = v.rt_ex;
        hz1.rs_id           = v.rs_id;
        hz1.rt_id           = v.rt_id;
        hz1.uses_rt_id      = v.urt;
        hz1.jump_id         = v.jump;
        hz1.branch_taken_ex = v.br;
        hz1.mem_access_mem  = v.ma;
        hz1.dmem_ready      = v.rdy;
    endtask

    task automatic drive3(input in_t v);
        hz3.mem_read_ex     = v.mr;
        hz3.rt_ex           = v.rt_ex;
        hz3.rs_id           = v.rs_id;
        hz3.rt_id           = v.rt_id;
        hz3.uses_rt_id      = v.urt;
        hz3.jump_id         = v.jump;
        hz3.branch_taken_ex = v.br;
        hz3.mem_access_mem  = v.ma;
        hz3.dmem_ready      = v.rdy;
    endtask

    // One clock cycle: drive at negedge, push expectation, sample 1 ns later and compare.
    task automatic step(input int dut, input in_t v, input logic rst_v,
                        input logic [5:0] exp, input logic [5:0] mask, input string tag);
        exp_t e;
        @(negedge clk);
        reset = rst_v;
        if (dut == 1) begin
            drive1(v);
            drive3(idle);
        end else begin
            drive1(idle);
            drive3(v);
        end
        sb.push_back('{tag: tag, dut: dut, exp: exp, mask: mask});
        #1;
        e = sb.pop_front();
        check(e.tag, 32'((e.dut == 1 ? out1 : out3) & e.mask), 32'(e.exp & e.mask));
    endtask

    in_t haz_rs, haz_rt, haz_rt_nouse, haz_zero, frz, jmp, brn, haz_br;

    initial begin
        idle         = mk_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        haz_rs       = mk_in(1'b1, 5'd8, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        haz_rt       = mk_in(1'b1, 5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        haz_rt_nouse = mk_in(1'b1, 5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        haz_zero     = mk_in(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        frz          = mk_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        jmp          = mk_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        brn          = mk_in(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        haz_br       = mk_in(1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        reset = 1'b0;
        drive1(idle);
        drive3(idle);

        // Reset: everything low even with a hazard or jump presented.
        step(1, haz_rs, 1'b0, O_RST, M_ALL, "rst_dut1_hazard");
        step(3, jmp,    1'b0, O_RST, M_ALL, "rst_dut3_jump");

        // Perf scenario on LL=3: one 3-bubble stall and one jump.
        step(3, haz_rt, 1'b1, O_STALL, M_ALL, "perf_stall1");
        step(3, idle,   1'b1, O_STALL, M_ALL, "perf_stall2");
        step(3, idle,   1'b1, O_STALL, M_ALL, "perf_stall3");
        step(3, jmp,    1'b1, O_JMP,   M_FLUSH, "perf_jump");
        step(3, idle,   1'b1, O_RUN,   M_ALL, "perf_run");
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cnt3, 32'd3);
        check("flush_cnt", flush_cnt3, 32'd1);
`endif
        step(3, idle, 1'b0, O_RST, M_ALL, "perf_rst_a");
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt_rst", stall_cnt3, 32'd0);
        check("flush_cnt_rst", flush_cnt3, 32'd0);
`endif
        step(3, idle, 1'b0, O_RST, M_ALL, "perf_rst_held");

        // LL=1 load-use on rs: single bubble, then run.
        step(1, haz_rs, 1'b1, O_STALL, M_ALL, "ll1_bubble");
        step(1, idle,   1'b1, O_RUN,   M_ALL, "ll1_resume");

        // LL=3 load-use on rt: exactly three bubbles.
        step(3, haz_rt, 1'b1, O_STALL, M_ALL, "ll3_b1");
        step(3, idle,   1'b1, O_STALL, M_ALL, "ll3_b2");
        step(3, idle,   1'b1, O_STALL, M_ALL, "ll3_b3");
        step(3, idle,   1'b1, O_RUN,   M_ALL, "ll3_run");

        // No hazard when rt is not read, or when the load targets $zero.
        step(3, haz_rt_nouse, 1'b1, O_RUN, M_ALL, "ll3_rt_unused");
        step(3, haz_zero,     1'b1, O_RUN, M_ALL, "ll3_reg_zero");

        // Branch in the second stall cycle aborts the stall.
        step(3, haz_rt, 1'b1, O_STALL, M_ALL, "br_b1");
        step(3, brn,    1'b1, O_BR,    M_FLUSH, "br_flush");
        step(3, idle,   1'b1, O_RUN,   M_ALL, "br_run");

        // Freeze for 4 cycles mid-stall (lcnt=2); jump/branch during freeze are ignored.
        step(3, haz_rt, 1'b1, O_STALL, M_ALL, "frz_b1");
        step(3, frz,    1'b1, O_FRZ,   M_ALL, "frz_1");
        frz.jump = 1'b1;
        step(3, frz,    1'b1, O_FRZ,   M_ALL, "frz_2_jump");
        frz.jump = 1'b0;
        frz.br   = 1'b1;
        step(3, frz,    1'b1, O_FRZ,   M_ALL, "frz_3_branch");
        frz.br   = 1'b0;
        step(3, frz,    1'b1, O_FRZ,   M_ALL, "frz_4");
        step(3, idle,   1'b1, O_STALL, M_ALL, "frz_b2");
        step(3, idle,   1'b1, O_STALL, M_ALL, "frz_b3");
        step(3, idle,   1'b1, O_RUN,   M_ALL, "frz_run");

        // A jump during a stall waits for the stall to end.
        haz_rt.jump = 1'b1;
        step(3, haz_rt, 1'b1, O_STALL, M_ALL, "jw_b1");
        step(3, jmp,    1'b1, O_STALL, M_ALL, "jw_b2");
        step(3, jmp,    1'b1, O_STALL, M_ALL, "jw_b3");
        step(3, jmp,    1'b1, O_JMP,   M_FLUSH, "jw_jump");
        step(3, idle,   1'b1, O_RUN,   M_ALL, "jw_run");
        haz_rt.jump = 1'b0;

        // Branch beats a simultaneous hazard; no stall entered.
        step(3, haz_br, 1'b1, O_BR,  M_FLUSH, "brhaz_ll3");
        step(3, idle,   1'b1, O_RUN, M_ALL, "brhaz_ll3_run");
        step(1, jmp,    1'b1, O_JMP, M_FLUSH, "ll1_jump");
        step(1, haz_br, 1'b1, O_BR,  M_FLUSH, "brhaz_ll1");

        // Freeze in RUN, release with a hazard present: restored RUN stalls.
        haz_rs.ma  = 1'b1;
        haz_rs.rdy = 1'b0;
        step(1, haz_rs, 1'b1, O_FRZ,   M_ALL, "ll1_frz");
        haz_rs.rdy = 1'b1;
        step(1, haz_rs, 1'b1, O_STALL, M_ALL, "ll1_frz_release");
        step(1, idle,   1'b1, O_RUN,   M_ALL, "ll1_frz_run");

        // Reset mid-stall returns straight to RUN.
        step(3, haz_rt, 1'b1, O_STALL, M_ALL, "rstmid_b1");
        step(3, idle,   1'b0, O_RST,   M_ALL, "rstmid_reset");
        step(3, idle,   1'b1, O_RUN,   M_ALL, "rstmid_run");

        // Reset mid-wait likewise.
        step(3, frz,    1'b1, O_FRZ,   M_ALL, "rstwait_frz");
        step(3, idle,   1'b0, O_RST,   M_ALL, "rstwait_reset");
        step(3, idle,   1'b1, O_RUN,   M_ALL, "rstwait_run");

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
